nw_linear_array: RTL

Parametrised linear systolic array that computes the global Needleman-Wunsch alignment score of a stored query against a streamed reference of arbitrary length. It uses one processing element (PE) per query character, with `PE_COUNT` PEs. Each reference character is accepted over a valid/ready stream and passes one PE per cycle. This block succeeds the fixed square-grid scorer: query length, scoring weights and score width are runtime or compile-time parameters, and the block has a real input handshake, bubbles, error reporting and an optional local-alignment mode. It sits between the DNA character feeder and the score collector.

---
 rtl/nw_pkg.sv | 32 +++
 rtl/nw_pe.sv | 98 +++++++++
 rtl/nw_linear_array.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared FSM states, score types and saturating arithmetic for nw_linear_array
package nw_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_Q, STREAM, DRAIN, DONE} state_t;

    localparam int SWIDTH_DEF = 16;
    typedef logic signed [SWIDTH_DEF-1:0] score_t;

    // Wide enough to hold the sum of two 32-bit scores without wrapping.
    typedef logic signed [33:0] wide_t;

    function automatic wide_t sat(input wide_t v, input int sw);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (sw - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int sw);
        return sat(a + b, sw);
    endfunction

    function automatic wide_t max3(input wide_t d, input wide_t u, input wide_t l);
        if (d >= u && d >= l) return d;
        if (u >= l) return u;
        return l;
    endfunction

endpackage

// File: rtl/nw_pe.sv
// rtl/nw_pe.sv - one alignment cell: stored query char, left/diag scores and the valid/last shift bits
module nw_pe
    import nw_pkg::*;
#(
    parameter int IDX      = 0,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int INDEL    = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_load,
    input  logic [CWIDTH-1:0]        i_q_char,
    input  logic                     i_valid,
    input  logic [CWIDTH-1:0]        i_char,
    input  logic                     i_last,
    input  logic signed [SWIDTH-1:0] i_up,
    output logic                     o_valid,
    output logic [CWIDTH-1:0]        o_char,
    output logic                     o_last,
    output logic signed [SWIDTH-1:0] o_h,
    output logic signed [SWIDTH-1:0] o_max
);

`ifdef NW_LOCAL_EN
    localparam logic signed [SWIDTH-1:0] INIT_L = '0;
    localparam logic signed [SWIDTH-1:0] INIT_D = '0;
`else
    localparam logic signed [SWIDTH-1:0] INIT_L = SWIDTH'(sat(wide_t'((IDX + 1) * INDEL), SWIDTH));
    localparam logic signed [SWIDTH-1:0] INIT_D = SWIDTH'(sat(wide_t'(IDX * INDEL), SWIDTH));
`endif

    logic [CWIDTH-1:0]        r_q;
    logic [CWIDTH-1:0]        r_char;
    logic                     r_valid;
    logic                     r_last;
    logic signed [SWIDTH-1:0] r_left;
    logic signed [SWIDTH-1:0] r_diag;
    wide_t                    w_h;

    always_comb begin
        w_h = max3(sat_add(wide_t'(r_diag), wide_t'((r_q == i_char) ? MATCH : MISMATCH), SWIDTH),
                   sat_add(wide_t'(i_up), wide_t'(INDEL), SWIDTH),
                   sat_add(wide_t'(r_left), wide_t'(INDEL), SWIDTH));
`ifdef NW_LOCAL_EN
        if (w_h < 0) w_h = '0;
`endif
    end

    // diag only advances on valid beats so bubbles leave the recurrence untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_left  <= '0;
            r_diag  <= '0;
        end else begin
            r_valid <= i_valid & ~i_clr;
            r_char  <= i_char;
            r_last  <= i_last;
            if (i_load) begin
                r_q    <= i_q_char;
                r_left <= INIT_L;
                r_diag <= INIT_D;
            end else if (i_valid) begin
                r_left <= w_h[SWIDTH-1:0];
                r_diag <= i_up;
            end
        end
    end

`ifdef NW_LOCAL_EN
    logic signed [SWIDTH-1:0] r_max;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_max <= '0;
        end else if (i_valid && w_h > wide_t'(r_max)) begin
            r_max <= w_h[SWIDTH-1:0];
        end
    end

    assign o_max = r_max;
`else
    assign o_max = r_left;
`endif

    assign o_valid = r_valid;
    assign o_char  = r_char;
    assign o_last  = r_last;
    assign o_h     = r_left;

endmodule

// File: rtl/nw_linear_array.sv
// rtl/nw_linear_array.sv - systolic Needleman-Wunsch scorer; define NW_LOCAL_EN for Smith-Waterman local mode
module nw_linear_array
    import nw_pkg::*;
#(
    parameter int PE_COUNT  = 16,
    parameter int CWIDTH    = 2,
    parameter int SWIDTH    = 16,
    parameter int LEN_WIDTH = 16,
    parameter int MATCH     = 1,
    parameter int MISMATCH  = -1,
    parameter int INDEL     = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     q_len,
    input  logic                     q_valid,
    input  logic [CWIDTH-1:0]        q_char,
    output logic                     q_ready,
    input  logic                     r_valid,
    input  logic [CWIDTH-1:0]        r_char,
    input  logic                     r_last,
    output logic                     r_ready,
    output logic                     busy,
    output logic signed [SWIDTH-1:0] score,
    output logic                     score_valid,
    output logic                     err
);

    localparam int SELW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

    state_t                   r_state;
    state_t                   w_next;
    logic [LEN_WIDTH-1:0]     r_qlen;
    logic [LEN_WIDTH-1:0]     r_cnt;
    logic [LEN_WIDTH-1:0]     r_rlen;
    logic signed [SWIDTH-1:0] r_bnd;
    logic signed [SWIDTH-1:0] r_in_up;
    logic signed [SWIDTH-1:0] r_score;
    logic [CWIDTH-1:0]        r_in_char;
    logic                     r_in_valid;
    logic                     r_in_last;
    logic                     r_err;

    logic                     w_start;
    logic                     w_bad;
    logic                     w_q_acc;
    logic                     w_r_acc;
    logic                     w_fin;
    logic [SELW-1:0]          w_sel;
    logic signed [SWIDTH-1:0] w_bnd_nxt;
    logic signed [SWIDTH-1:0] w_best;
    logic                     w_unused;

    logic [PE_COUNT-1:0]      w_iv, w_il, w_ov, w_ol;
    logic [CWIDTH-1:0]        w_ic [PE_COUNT];
    logic [CWIDTH-1:0]        w_oc [PE_COUNT];
    logic signed [SWIDTH-1:0] w_iu [PE_COUNT];
    logic signed [SWIDTH-1:0] w_h  [PE_COUNT];
    logic signed [SWIDTH-1:0] w_max[PE_COUNT];

    assign w_start = start && (r_state == IDLE || r_state == DONE);
    assign w_bad   = (q_len == '0) || (q_len > LEN_WIDTH'(PE_COUNT));
    assign w_q_acc = (r_state == LOAD_Q) && q_valid;
    assign w_r_acc = (r_state == STREAM) && r_valid;
    assign w_sel   = SELW'(r_qlen - LEN_WIDTH'(1));
    assign w_fin   = w_ov[w_sel] && w_ol[w_sel];

`ifdef NW_LOCAL_EN
    assign w_bnd_nxt = '0;

    always_comb begin
        w_best = '0;
        for (int i = 0; i < PE_COUNT; i++) begin
            if (LEN_WIDTH'(i) < r_qlen && w_max[i] > w_best) w_best = w_max[i];
        end
    end
`else
    assign w_bnd_nxt = SWIDTH'(sat_add(wide_t'(r_bnd), wide_t'(INDEL), SWIDTH));
    assign w_best    = w_max[w_sel];
`endif

    always_comb begin
        w_next      = r_state;
        q_ready     = 1'b0;
        r_ready     = 1'b0;
        busy        = 1'b1;
        score_valid = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                busy        = 1'b0;
                score_valid = (r_state == DONE);
                if (start) w_next = w_bad ? DONE : LOAD_Q;
            end
            LOAD_Q: begin
                q_ready = 1'b1;
                if (q_valid && r_cnt == r_qlen - LEN_WIDTH'(1)) w_next = STREAM;
            end
            STREAM: begin
                r_ready = 1'b1;
                if (r_valid && r_last) w_next = DRAIN;
            end
            DRAIN:   if (w_fin) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_qlen     <= '0;
            r_cnt      <= '0;
            r_rlen     <= '0;
            r_bnd      <= '0;
            r_in_up    <= '0;
            r_in_char  <= '0;
            r_in_valid <= 1'b0;
            r_in_last  <= 1'b0;
            r_score    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_valid <= w_r_acc;
            r_in_char  <= r_char;
            r_in_last  <= r_last & w_r_acc;
            if (w_start) begin
                r_qlen <= q_len;
                r_cnt  <= '0;
                r_rlen <= '0;
                r_bnd  <= '0;
                r_err  <= w_bad;
                if (w_bad) r_score <= '0;
            end
            if (w_q_acc) r_cnt <= r_cnt + LEN_WIDTH'(1);
            // Reference overflow is flagged but the job still completes normally.
            if (w_r_acc) begin
                r_bnd   <= w_bnd_nxt;
                r_in_up <= w_bnd_nxt;
                if (r_rlen != '1) r_rlen <= r_rlen + LEN_WIDTH'(1);
                if (r_rlen >= {{(LEN_WIDTH-1){1'b1}}, 1'b0}) r_err <= 1'b1;
            end
            if (r_state == DRAIN && w_fin) r_score <= w_best;
        end
    end

    for (genvar g = 0; g < PE_COUNT; g++) begin : g_pe
        if (g == 0) begin : g_head
            assign w_iv[0] = r_in_valid;
            assign w_il[0] = r_in_last;
            assign w_ic[0] = r_in_char;
            assign w_iu[0] = r_in_up;
        end else begin : g_link
            assign w_iv[g] = w_ov[g-1];
            assign w_il[g] = w_ol[g-1];
            assign w_ic[g] = w_oc[g-1];
            assign w_iu[g] = w_h[g-1];
        end

        nw_pe #(
            .IDX(g), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
            .MATCH(MATCH), .MISMATCH(MISMATCH), .INDEL(INDEL)
        ) u_pe (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (w_start),
            .i_load  (w_q_acc && r_cnt == LEN_WIDTH'(g)),
            .i_q_char(q_char),
            .i_valid (w_iv[g]),
            .i_char  (w_ic[g]),
            .i_last  (w_il[g]),
            .i_up    (w_iu[g]),
            .o_valid (w_ov[g]),
            .o_char  (w_oc[g]),
            .o_last  (w_ol[g]),
            .o_h     (w_h[g]),
            .o_max   (w_max[g])
        );
    end

    assign w_unused = ^{w_oc[PE_COUNT-1], w_h[PE_COUNT-1]};

    assign score = r_score;
    assign err   = r_err;

endmodule
